hwpe_ctrl_periph_arbiter: RTL and testbench

- Upstream stage of the HWPE control slave. Merges N_CORES per-core peripheral request ports into the single slave cfg port.
- Arbitrates round-robin and stamps each request with a one-hot ID so the slave can track the offloading core.
- Routes responses back to the requesting core by r_id.
- Keeps a critical-section lock: after a core's test&set read, only that core is granted until it writes the trigger register, or until a timeout or clear.

---
 rtl/hwpe_ctrl_periph_arbiter_pkg.sv | 18 +
 rtl/hwpe_ctrl_periph_arbiter_if.sv | 29 ++
 rtl/hwpe_ctrl_periph_arbiter_rr.sv | 35 +++
 rtl/hwpe_ctrl_periph_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_hwpe_ctrl_periph_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_ctrl_periph_arbiter_pkg.sv
// Shared constants and types for the HWPE control peripheral arbiter.
// Register-field indices are the word offsets in add[5:2].
package hwpe_ctrl_package;

    localparam logic [3:0] ARB_TESTSET_IDX = 4'd1;
    localparam logic [3:0] ARB_TRIGGER_IDX = 4'd0;
    localparam logic [3:0] ARB_SOFTCLR_IDX = 4'd5;

    localparam int unsigned ARB_OWNER_W = 4;
    localparam int unsigned ARB_CNT_W   = 16;

    typedef struct packed {
        logic                   valid;
        logic [ARB_OWNER_W-1:0] owner;
        logic [ARB_CNT_W-1:0]   cnt;
    } arb_lock_t;

endpackage

// File: rtl/hwpe_ctrl_periph_arbiter_if.sv
// Slave cfg port bundle between the peripheral arbiter and the HWPE control slave.
// Handshake: a request transfers in every cycle where req and gnt are both high; the master
// holds req and its payload stable until then. Responses are single-cycle r_valid pulses tagged by r_id.
interface hwpe_ctrl_periph_arbiter_if #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned ID_WIDTH = 16
);
    logic                req;
    logic                gnt;
    logic [AW-1:0]       add;
    logic                wen;
    logic [DW/8-1:0]     be;
    logic [DW-1:0]       data;
    logic [ID_WIDTH-1:0] id;
    logic [DW-1:0]       r_data;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );
endinterface

// File: rtl/hwpe_ctrl_periph_arbiter_rr.sv
// Parametric N-way round-robin pick: first set bit of (req & mask) at or after ptr, wrapping.
// Returns a one-hot grant and its binary index (index is 0 when nothing is granted).
module hwpe_ctrl_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [N-1:0] eligible;
    logic         found;
    int unsigned  k;

    always_comb begin
        eligible = req_i & mask_i;
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        k        = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = int'(ptr_i) + i;
            if (k >= N) k = k - N;
            if (!found && eligible[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/hwpe_ctrl_periph_arbiter.sv
// Merges N_CORES peripheral ports onto the HWPE control slave cfg port with round-robin
// arbitration, one-hot source IDs and a test&set lock. HWPE_CTRL_ARB_REG_EN adds a request register slice.
module hwpe_ctrl_periph_arbiter
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_CORES      = 4,
    parameter int unsigned ID_WIDTH     = 16,
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned LOCK_TIMEOUT = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [N_CORES-1:0]     core_req_i,
    output logic [N_CORES-1:0]     core_gnt_o,
    input  logic [N_CORES*AW-1:0]  core_add_i,
    input  logic [N_CORES-1:0]     core_wen_i,
    input  logic [N_CORES*DW/8-1:0] core_be_i,
    input  logic [N_CORES*DW-1:0]  core_data_i,
    output logic [DW-1:0]          core_r_data_o,
    output logic [N_CORES-1:0]     core_r_valid_o,
    hwpe_ctrl_periph_arbiter_if.master cfg
);

    localparam int unsigned IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    arb_lock_t          lock_q, lock_d;
    logic [N_CORES-1:0] elig_mask, win_onehot;
    logic [IW-1:0]      win_idx;
    logic               win_valid, accept;
    logic [AW-1:0]      win_add;
    logic               win_wen;
    logic [DW/8-1:0]    win_be;
    logic [DW-1:0]      win_data;
    logic [ID_WIDTH-1:0] win_id;
    logic [3:0]         win_field;

    // While locked only the owner may compete; everyone else keeps its request pending.
    always_comb begin
        for (int unsigned i = 0; i < N_CORES; i++)
            elig_mask[i] = !lock_q.valid || (lock_q.owner == ARB_OWNER_W'(i));
    end

    hwpe_ctrl_rr_arbiter #(.N(N_CORES), .IW(IW)) i_rr (
        .req_i  (core_req_i),
        .mask_i (elig_mask),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (win_onehot),
        .idx_o  (win_idx)
    );

    assign win_valid = |win_onehot;
    assign win_id    = ID_WIDTH'(win_onehot);

    always_comb begin
        win_add  = '0;
        win_wen  = 1'b0;
        win_be   = '0;
        win_data = '0;
        if (win_valid) begin
            win_add  = core_add_i[int'(win_idx)*AW +: AW];
            win_wen  = core_wen_i[win_idx];
            win_be   = core_be_i[int'(win_idx)*(DW/8) +: DW/8];
            win_data = core_data_i[int'(win_idx)*DW +: DW];
        end
    end
    assign win_field = win_add[5:2];

`ifdef HWPE_CTRL_ARB_REG_EN
    logic                slice_vld_q, slice_vld_d;
    logic [AW-1:0]       slice_add_q, slice_add_d;
    logic                slice_wen_q, slice_wen_d;
    logic [DW/8-1:0]     slice_be_q, slice_be_d;
    logic [DW-1:0]       slice_data_q, slice_data_d;
    logic [ID_WIDTH-1:0] slice_id_q, slice_id_d;

    assign accept = win_valid & (~slice_vld_q | cfg.gnt);

    always_comb begin
        slice_vld_d  = slice_vld_q;
        slice_add_d  = slice_add_q;
        slice_wen_d  = slice_wen_q;
        slice_be_d   = slice_be_q;
        slice_data_d = slice_data_q;
        slice_id_d   = slice_id_q;
        if (accept) begin
            slice_vld_d  = 1'b1;
            slice_add_d  = win_add;
            slice_wen_d  = win_wen;
            slice_be_d   = win_be;
            slice_data_d = win_data;
            slice_id_d   = win_id;
        end else if (cfg.gnt) begin
            slice_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slice_vld_q  <= 1'b0;
            slice_add_q  <= '0;
            slice_wen_q  <= 1'b0;
            slice_be_q   <= '0;
            slice_data_q <= '0;
            slice_id_q   <= '0;
        end else begin
            slice_vld_q  <= slice_vld_d;
            slice_add_q  <= slice_add_d;
            slice_wen_q  <= slice_wen_d;
            slice_be_q   <= slice_be_d;
            slice_data_q <= slice_data_d;
            slice_id_q   <= slice_id_d;
        end
    end

    assign cfg.req  = slice_vld_q;
    assign cfg.add  = slice_add_q;
    assign cfg.wen  = slice_wen_q;
    assign cfg.be   = slice_be_q;
    assign cfg.data = slice_data_q;
    assign cfg.id   = slice_id_q;
`else
    assign accept   = win_valid & cfg.gnt;
    assign cfg.req  = win_valid;
    assign cfg.add  = win_add;
    assign cfg.wen  = win_wen;
    assign cfg.be   = win_be;
    assign cfg.data = win_data;
    assign cfg.id   = win_id;
`endif

    assign core_gnt_o = win_onehot & {N_CORES{accept}};

    // Lock and pointer advance on the accepted transfer; clear_i overrides everything.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        lock_d   = lock_q;
        if (lock_q.valid && (lock_q.cnt != '1))
            lock_d.cnt = lock_q.cnt + 1'b1;
        if (accept) begin
            rr_ptr_d = (win_idx == IW'(N_CORES-1)) ? '0 : win_idx + 1'b1;
            if (win_wen && (win_field == ARB_TESTSET_IDX)) begin
                lock_d.valid = 1'b1;
                lock_d.owner = ARB_OWNER_W'(win_idx);
                lock_d.cnt   = '0;
            end else if (lock_q.valid && !win_wen &&
                         ((win_field == ARB_TRIGGER_IDX) || (win_field == ARB_SOFTCLR_IDX))) begin
                lock_d.valid = 1'b0;
                lock_d.cnt   = '0;
            end
        end
        if ((LOCK_TIMEOUT > 0) && lock_q.valid && (lock_q.cnt == ARB_CNT_W'(LOCK_TIMEOUT-1))) begin
            lock_d.valid = 1'b0;
            lock_d.cnt   = '0;
        end
        if (clear_i) begin
            rr_ptr_d = '0;
            lock_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            lock_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
        end
    end

    // Responses carrying a zero or multi-hot ID belong to nobody and are dropped.
    logic r_id_onehot;
    assign r_id_onehot    = (cfg.r_id != '0) && ((cfg.r_id & (cfg.r_id - 1'b1)) == '0);
    assign core_r_valid_o = {N_CORES{cfg.r_valid & r_id_onehot}} & cfg.r_id[N_CORES-1:0];
    assign core_r_data_o  = cfg.r_data;

endmodule

// File: tb/tb_hwpe_ctrl_periph_arbiter.sv
// Self-checking bench for hwpe_ctrl_periph_arbiter (N_CORES=4, LOCK_TIMEOUT=16).
module tb_hwpe_ctrl_periph_arbiter;
  import hwpe_ctrl_package::*;

  localparam int N   = 4;
  localparam int IDW = 16;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO  = 16;
`ifdef HWPE_CTRL_ARB_REG_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            clear_i;
  logic [N-1:0]    core_req_i, core_gnt_o, core_wen_i, core_r_valid_o;
  logic [N*AW-1:0] core_add_i;
  logic [N*DW/8-1:0] core_be_i;
  logic [N*DW-1:0] core_data_i;
  logic [DW-1:0]   core_r_data_o;

  hwpe_ctrl_periph_arbiter_if #(.AW(AW), .DW(DW), .ID_WIDTH(IDW)) cfg ();

  hwpe_ctrl_periph_arbiter #(
    .N_CORES(N), .ID_WIDTH(IDW), .AW(AW), .DW(DW), .LOCK_TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_add_i(core_add_i),
    .core_wen_i(core_wen_i), .core_be_i(core_be_i), .core_data_i(core_data_i),
    .core_r_data_o(core_r_data_o), .core_r_valid_o(core_r_valid_o),
    .cfg(cfg.master)
  );

  // clock/reset
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [IDW-1:0] exp_q[$];
  logic [N-1:0]   gnt_q[$];

  // driver tasks
  task automatic drive_idle();
    core_req_i = '0; core_wen_i = '0; core_add_i = '0; core_be_i = '0; core_data_i = '0;
    clear_i = 1'b0; cfg.gnt = 1'b0; cfg.r_valid = 1'b0; cfg.r_id = '0; cfg.r_data = '0;
  endtask

  task automatic set_core(input int i, input logic req, input logic wen,
                          input logic [AW-1:0] add, input logic [DW-1:0] data);
    core_req_i[i] = req;
    core_wen_i[i] = wen;
    core_add_i[i*AW +: AW] = add;
    core_data_i[i*DW +: DW] = data;
    core_be_i[i*(DW/8) +: DW/8] = '1;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_ni = 1'b0;
    @(negedge clk_i);
    n_tests++; if (cfg.req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", cfg.req); end
    n_tests++; if (core_gnt_o !== 4'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", core_gnt_o); end
    n_tests++; if (cfg.id !== 16'h0) begin n_fail++; $display("FAIL reset_id: got %h want 0000", cfg.id); end
    n_tests++; if (core_r_valid_o !== 4'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0000", core_r_valid_o); end
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_rotation();
    int cyc;
    logic [N-1:0]   eg;
    logic [IDW-1:0] ei;
    do_reset();
    gnt_q.delete(); exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      gnt_q.push_back((k % 2 == 0) ? 4'b0001 : 4'b0100);
      exp_q.push_back((k % 2 == 0) ? 16'h0001 : 16'h0004);
    end
    cfg.gnt = 1'b1;
    set_core(0, 1'b1, 1'b1, 32'h10, 32'h0);
    set_core(2, 1'b1, 1'b1, 32'h10, 32'h0);
    cyc = 0;
    while ((gnt_q.size() > 0 || exp_q.size() > 0) && cyc < 12) begin
      @(negedge clk_i);
      if (core_gnt_o != '0 && gnt_q.size() > 0) begin
        eg = gnt_q.pop_front();
        n_tests++; if (core_gnt_o !== eg) begin n_fail++; $display("FAIL rot_gnt: got %b want %b", core_gnt_o, eg); end
      end
      if (cfg.req && cfg.gnt && exp_q.size() > 0) begin
        ei = exp_q.pop_front();
        n_tests++; if (cfg.id !== ei) begin n_fail++; $display("FAIL rot_id: got %h want %h", cfg.id, ei); end
      end
      tick();
      if (gnt_q.size() == 0) begin
        set_core(0, 1'b0, 1'b1, 32'h10, 32'h0);
        set_core(2, 1'b0, 1'b1, 32'h10, 32'h0);
      end
      cyc++;
    end
    n_tests++;
    if (gnt_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rot_timeout: pending gnt %0d id %0d want 0", gnt_q.size(), exp_q.size());
    end
    drive_idle();
  endtask

  task automatic test_lock_hold();
    do_reset();
    cfg.gnt = 1'b1;
    set_core(1, 1'b1, 1'b1, 32'h04, 32'h0);
    @(negedge clk_i);
    n_tests++; if (core_gnt_o !== 4'b0010) begin n_fail++; $display("FAIL lock_ts_gnt: got %b want 0010", core_gnt_o); end
    tick();
    set_core(1, 1'b0, 1'b1, 32'h04, 32'h0);
    set_core(3, 1'b1, 1'b1, 32'h10, 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      n_tests++; if (core_gnt_o !== 4'b0000) begin n_fail++; $display("FAIL lock_hold c%0d: got %b want 0000", c, core_gnt_o); end
      tick();
    end
    set_core(1, 1'b1, 1'b0, 32'h00, 32'h1);
    @(negedge clk_i);
    n_tests++; if (core_gnt_o !== 4'b0010) begin n_fail++; $display("FAIL lock_trig_gnt: got %b want 0010", core_gnt_o); end
    tick();
    set_core(1, 1'b0, 1'b0, 32'h00, 32'h1);
    @(negedge clk_i);
    n_tests++; if (core_gnt_o !== 4'b1000) begin n_fail++; $display("FAIL lock_release_gnt: got %b want 1000", core_gnt_o); end
    tick();
    drive_idle();
  endtask

  task automatic test_timeout();
    int seen;
    do_reset();
    cfg.gnt = 1'b1;
    set_core(0, 1'b1, 1'b1, 32'h04, 32'h0);
    @(negedge clk_i);
    n_tests++; if (core_gnt_o !== 4'b0001) begin n_fail++; $display("FAIL to_ts_gnt: got %b want 0001", core_gnt_o); end
    tick();
    set_core(0, 1'b0, 1'b1, 32'h04, 32'h0);
    set_core(2, 1'b1, 1'b1, 32'h10, 32'h0);
    seen = -1;
    for (int n = 0; n < 40 && seen < 0; n++) begin
      @(negedge clk_i);
      if (core_gnt_o[2]) seen = n;
      tick();
    end
    n_tests++; if (seen !== TO) begin n_fail++; $display("FAIL to_delay: got %0d want %0d cycles", seen, TO); end
    drive_idle();
  endtask

  task automatic test_response();
    logic [IDW-1:0] ids[4];
    logic [N-1:0]   e;
    ids[0] = 16'h0008; ids[1] = 16'h0006; ids[2] = 16'h0000; ids[3] = 16'h0002;
    do_reset();
    gnt_q.delete();
    for (int k = 0; k < 4; k++) begin
      gnt_q.push_back((k == 0) ? 4'b1000 : (k == 3) ? 4'b0010 : 4'b0000);
      cfg.r_valid = 1'b1;
      cfg.r_id = ids[k];
      cfg.r_data = 32'hCAFE + k;
      @(negedge clk_i);
      e = gnt_q.pop_front();
      n_tests++; if (core_r_valid_o !== e) begin n_fail++; $display("FAIL rsp_valid id=%h: got %b want %b", ids[k], core_r_valid_o, e); end
      n_tests++; if (core_r_data_o !== 32'hCAFE + k) begin n_fail++; $display("FAIL rsp_data: got %h want %h", core_r_data_o, 32'hCAFE + k); end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_clear();
    do_reset();
    cfg.gnt = 1'b1;
    set_core(2, 1'b1, 1'b1, 32'h04, 32'h0);
    @(negedge clk_i);
    n_tests++; if (core_gnt_o !== 4'b0100) begin n_fail++; $display("FAIL clr_ts_gnt: got %b want 0100", core_gnt_o); end
    tick();
    set_core(2, 1'b0, 1'b1, 32'h04, 32'h0);
    set_core(0, 1'b1, 1'b1, 32'h10, 32'h0);
    clear_i = 1'b1;
    @(negedge clk_i);
    n_tests++; if (core_gnt_o !== 4'b0000) begin n_fail++; $display("FAIL clr_locked_gnt: got %b want 0000", core_gnt_o); end
    tick();
    clear_i = 1'b0;
    @(negedge clk_i);
    n_tests++; if (core_gnt_o !== 4'b0001) begin n_fail++; $display("FAIL clr_after_gnt: got %b want 0001", core_gnt_o); end
    tick();
    set_core(1, 1'b1, 1'b1, 32'h10, 32'h0);
    set_core(3, 1'b1, 1'b1, 32'h10, 32'h0);
    @(negedge clk_i);
    n_tests++; if (core_gnt_o !== 4'b0010) begin n_fail++; $display("FAIL clr_ptr_gnt: got %b want 0010", core_gnt_o); end
    tick();
    drive_idle();
  endtask

  task automatic test_back_pressure();
    logic [N-1:0] eg;
    logic         er;
    do_reset();
    cfg.gnt = 1'b0;
    set_core(1, 1'b1, 1'b0, 32'h20, 32'h1234_5678);
    for (int c = 0; c < 5; c++) begin
      eg = (REG_EN && c == 0) ? 4'b0010 : 4'b0000;
      er = !(REG_EN && c == 0);
      @(negedge clk_i);
      n_tests++; if (core_gnt_o !== eg) begin n_fail++; $display("FAIL bp_gnt c%0d: got %b want %b", c, core_gnt_o, eg); end
      n_tests++; if (cfg.req !== er) begin n_fail++; $display("FAIL bp_req c%0d: got %b want %b", c, cfg.req, er); end
      if (er) begin
        n_tests++;
        if (cfg.add !== 32'h20 || cfg.data !== 32'h1234_5678 || cfg.id !== 16'h0002) begin
          n_fail++; $display("FAIL bp_payload c%0d: got %h/%h/%h want 00000020/12345678/0002", c, cfg.add, cfg.data, cfg.id);
        end
      end
      tick();
      if (REG_EN && c == 0) set_core(1, 1'b0, 1'b0, 32'h20, 32'h1234_5678);
    end
    cfg.gnt = 1'b1;
    eg = REG_EN ? 4'b0000 : 4'b0010;
    @(negedge clk_i);
    n_tests++; if (core_gnt_o !== eg) begin n_fail++; $display("FAIL bp_release_gnt: got %b want %b", core_gnt_o, eg); end
    n_tests++; if ((cfg.req && cfg.gnt) !== 1'b1 || cfg.id !== 16'h0002) begin
      n_fail++; $display("FAIL bp_release_xfer: got req=%b id=%h want 1/0002", cfg.req, cfg.id);
    end
    tick();
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_rotation();
    test_lock_hold();
    test_timeout();
    test_response();
    test_clear();
    test_back_pressure();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
